sha256_round_ctrl: RTL and testbench

//  Sequencing controller for one SHA-256 block: accepts a 512-bit block via valid/ready, drives the

---
 rtl/sha256_round_ctrl_if.sv | 29 ++
 rtl/sha256_round_ctrl.sv | 95 +++++++++
 tb/tb_sha256_round_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_round_ctrl_if.sv
// Block handshake and schedule/compression strobes between the host, the
// round controller and the w_mem/compression datapath.
interface sha256_round_ctrl_if;
   logic       block_valid;
   logic       block_first;
   logic       block_ready;
   logic       abort;
   logic       w_init;
   logic       w_next;
   logic [5:0] round;
   logic       state_init;
   logic       digest_init;
   logic       round_en;
   logic       digest_update;
   logic       digest_valid;
   logic       busy;

   modport master (
      output block_valid, block_first, abort,
      input  block_ready, w_init, w_next, round, state_init, digest_init,
             round_en, digest_update, digest_valid, busy
   );

   modport slave (
      input  block_valid, block_first, abort,
      output block_ready, w_init, w_next, round, state_init, digest_init,
             round_en, digest_update, digest_valid, busy
   );
endinterface

// File: rtl/sha256_round_ctrl.sv
// Sequencing controller for one SHA-256 block: IDLE -> ROUNDS -> UPDATE -> IDLE.
// Holds no data; only drives w_mem and compression datapath strobes.
module sha256_round_ctrl #(
   parameter int NUM_ROUNDS = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   sha256_round_ctrl_if.slave bus
);
   localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROUNDS = 2'd1,
      UPDATE = 2'd2
   } state_t;

   state_t     state_reg, state_next;
   logic [5:0] round_reg, round_next;
   logic       digest_valid_reg, digest_valid_next;
   logic       accept;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= IDLE;
         round_reg        <= 6'd0;
         digest_valid_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         round_reg        <= round_next;
         digest_valid_reg <= digest_valid_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      round_next        = round_reg;
      digest_valid_next = digest_valid_reg;
      accept            = 1'b0;
      bus.block_ready   = 1'b0;
      bus.w_init        = 1'b0;
      bus.w_next        = 1'b0;
      bus.state_init    = 1'b0;
      bus.digest_init   = 1'b0;
      bus.round_en      = 1'b0;
      bus.digest_update = 1'b0;

      case (state_reg)
         IDLE: begin
            // Strobes here are combinational so the datapath loads on the accept edge itself.
            bus.block_ready = 1'b1;
            accept          = reset_n && bus.block_valid && !bus.abort;
            round_next      = 6'd0;
            if (accept) begin
               bus.w_init        = 1'b1;
               bus.state_init    = 1'b1;
               bus.digest_init   = bus.block_first;
               digest_valid_next = 1'b0;
               state_next        = ROUNDS;
            end else if (bus.abort) begin
               digest_valid_next = 1'b0;
            end
         end
         ROUNDS: begin
            bus.round_en = 1'b1;
            bus.w_next   = 1'b1;
            if (bus.abort) begin
               round_next = 6'd0;
               state_next = IDLE;
            end else if (round_reg == LAST_ROUND) begin
               round_next = 6'd0;
               state_next = UPDATE;
            end else begin
               round_next = round_reg + 6'd1;
            end
         end
         UPDATE: begin
            // An abort here suppresses the H accumulation, leaving digest_valid low.
            state_next = IDLE;
            if (!bus.abort) begin
               bus.digest_update = 1'b1;
               digest_valid_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            round_next = 6'd0;
         end
      endcase
   end

   assign bus.round        = round_reg;
   assign bus.digest_valid = digest_valid_reg;
   assign bus.busy         = (state_reg != IDLE);
endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: 64-round and 20-round builds driven in parallel,
// checked every cycle against an elapsed-cycle model plus literal latency checks.
module tb_sha256_round_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic valid = 1'b0;
   logic first = 1'b0;
   logic abort = 1'b0;

   always #5 clk = ~clk;

   sha256_round_ctrl_if if0 ();
   sha256_round_ctrl_if if1 ();

   assign if0.block_valid = valid;
   assign if0.block_first = first;
   assign if0.abort       = abort;
   assign if1.block_valid = valid;
   assign if1.block_first = first;
   assign if1.abort       = abort;

   sha256_round_ctrl #(.NUM_ROUNDS(64)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
   sha256_round_ctrl #(.NUM_ROUNDS(20)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));

   int n_checks = 0;
   int n_pass   = 0;

   // Model: cycles elapsed since accept (0 = idle), plus the digest_valid level.
   int m_cnt[2] = '{0, 0};
   bit m_dv[2]  = '{1'b0, 1'b0};

   function automatic int nr(int i);
      return (i == 0) ? 64 : 20;
   endfunction

   function automatic logic [14:0] exp_vec(int i);
      int         c   = m_cnt[i];
      logic       acc = valid && !abort;
      logic       rdy = 1'b0, wi = 1'b0, wn = 1'b0, si = 1'b0, di = 1'b0;
      logic       re = 1'b0, du = 1'b0, bz = 1'b0;
      logic [5:0] rd = 6'd0;
      if (c == 0) begin
         rdy = 1'b1; wi = acc; si = acc; di = acc && first;
      end else if (c <= nr(i)) begin
         re = 1'b1; wn = 1'b1; rd = 6'(c - 1); bz = 1'b1;
      end else begin
         du = !abort; bz = 1'b1;
      end
      return {rdy, wi, wn, rd, si, di, re, du, m_dv[i], bz};
   endfunction

   function automatic logic [14:0] act_vec(int i);
      if (i == 0)
         return {if0.block_ready, if0.w_init, if0.w_next, if0.round, if0.state_init,
                 if0.digest_init, if0.round_en, if0.digest_update, if0.digest_valid, if0.busy};
      return {if1.block_ready, if1.w_init, if1.w_next, if1.round, if1.state_init,
              if1.digest_init, if1.round_en, if1.digest_update, if1.digest_valid, if1.busy};
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_cnt <= '{0, 0};
         m_dv  <= '{1'b0, 1'b0};
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_cnt[i] == 0) begin
               if (valid && !abort) begin
                  m_cnt[i] <= 1;
                  m_dv[i]  <= 1'b0;
               end else if (abort) begin
                  m_dv[i] <= 1'b0;
               end
            end else if (abort) begin
               m_cnt[i] <= 0;
            end else if (m_cnt[i] == nr(i) + 1) begin
               m_cnt[i] <= 0;
               m_dv[i]  <= 1'b1;
            end else begin
               m_cnt[i] <= m_cnt[i] + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [14:0] e, a;
         e = exp_vec(i);
         a = act_vec(i);
         n_checks++;
         if (a === e) n_pass++;
         else $display("FAIL model dut%0d t=%0t: got %b required %b (rdy,wi,wn,round,si,di,re,du,dv,busy)",
                       i, $time, a, e);
      end
   end

   task automatic check(string name, int got, int req);
      n_checks++;
      if (got == req) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, got, req);
   endtask

   task automatic wait_round(int r, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (if0.round == 6'(r)) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      int rcnt[2], upd[2], dvc[2];
      int acc2, di2, dv_low_bad, dv132, du_cnt;
      bit ok;

      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      repeat (10) begin
         @(negedge clk);
         check("idle_ready", int'(if0.block_ready), 1);
         check("idle_busy_round", int'({if0.busy, if0.round, if0.round_en, if0.w_init}), 0);
      end

      // Single first block on both builds
      @(posedge clk); #1 valid = 1'b1; first = 1'b1;
      @(negedge clk);
      check("c0_w_init", int'(if0.w_init), 1);
      check("c0_state_init", int'(if0.state_init), 1);
      check("c0_digest_init", int'(if0.digest_init), 1);
      check("c0_w_init_20", int'(if1.w_init), 1);
      @(posedge clk); #1 valid = 1'b0; first = 1'b0;
      rcnt = '{0, 0}; upd = '{-1, -1}; dvc = '{-1, -1};
      for (int cyc = 1; cyc <= 70; cyc++) begin
         @(negedge clk);
         if (if0.round_en) rcnt[0]++;
         if (if1.round_en) rcnt[1]++;
         if (if0.round_en && cyc == 64) check("last_round_idx", int'(if0.round), 63);
         if (if0.digest_update) upd[0] = cyc;
         if (if1.digest_update) upd[1] = cyc;
         if (if0.digest_valid && dvc[0] < 0) dvc[0] = cyc;
         if (if1.digest_valid && dvc[1] < 0) dvc[1] = cyc;
      end
      check("round_en_cycles_64", rcnt[0], 64);
      check("digest_update_cyc_64", upd[0], 65);
      check("digest_valid_cyc_64", dvc[0], 66);
      check("round_en_cycles_20", rcnt[1], 20);
      check("digest_update_cyc_20", upd[1], 21);
      check("digest_valid_cyc_20", dvc[1], 22);

      // Two-block message, valid held high
      @(posedge clk); #1 valid = 1'b1; first = 1'b1;
      @(negedge clk);
      check("blk1_accept", int'(if0.w_init), 1);
      @(posedge clk); #1 first = 1'b0;
      acc2 = -1; di2 = -1; dv_low_bad = 0; dv132 = -1;
      for (int cyc = 1; cyc <= 135; cyc++) begin
         @(negedge clk);
         if (if0.w_init && acc2 < 0) begin acc2 = cyc; di2 = int'(if0.digest_init); end
         if (cyc >= 67 && cyc <= 131 && if0.digest_valid) dv_low_bad++;
         if (cyc == 132) dv132 = int'(if0.digest_valid);
      end
      check("blk2_accept_cyc", acc2, 66);
      check("blk2_digest_init", di2, 0);
      check("blk2_dv_low_67_131", dv_low_bad, 0);
      check("blk2_dv_at_132", dv132, 1);
      @(posedge clk); #1 valid = 1'b0;
      repeat (140) @(posedge clk);

      // Abort at round 30
      #1 valid = 1'b1; first = 1'b1;
      @(posedge clk); #1 valid = 1'b0;
      wait_round(29, ok);
      check("wait_round29", int'(ok), 1);
      @(posedge clk); #1 abort = 1'b1;
      @(negedge clk);
      check("abort_round", int'(if0.round), 30);
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check("abort_busy", int'(if0.busy), 0);
      check("abort_ready", int'(if0.block_ready), 1);
      check("abort_dv", int'(if0.digest_valid), 0);
      du_cnt = 0;
      repeat (80) begin @(negedge clk); if (if0.digest_update) du_cnt++; end
      check("abort_no_update", du_cnt, 0);

      // Abort with valid in IDLE blocks accept
      @(posedge clk); #1 valid = 1'b1; abort = 1'b1;
      @(negedge clk);
      check("idle_abort_w_init", int'(if0.w_init), 0);
      check("idle_abort_w_init_20", int'(if1.w_init), 0);
      @(posedge clk); #1 valid = 1'b0; abort = 1'b0;
      @(negedge clk);
      check("idle_abort_busy", int'(if0.busy), 0);

      // Async reset at round 40
      @(posedge clk); #1 valid = 1'b1; first = 1'b1;
      @(posedge clk); #1 valid = 1'b0;
      wait_round(39, ok);
      check("wait_round39", int'(ok), 1);
      @(posedge clk); #2 reset_n = 1'b0;
      #1;
      check("rst_mid_outputs", int'(act_vec(0)), int'(15'b100000000000000));
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      du_cnt = 0;
      repeat (80) begin @(negedge clk); if (if0.digest_update) du_cnt++; end
      check("rst_no_update", du_cnt, 0);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk); #1;
         valid = ($urandom % 3) == 0;
         first = $urandom % 2;
         abort = ($urandom % 40) == 0;
      end
      @(posedge clk); #1 valid = 1'b0; abort = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
